// File: rtl/vga_scanout.sv
// Raster timing generator and registered RGB/sync output stage for the character display.
// Strobes are decoded from the next raster position so they line up with the counters.
module vga_scanout #(
    parameter int BPP    = 2,
    parameter int H_VIS  = 640,
    parameter int H_FP   = 16,
    parameter int H_SYNC = 96,
    parameter int H_BP   = 48,
    parameter int V_VIS  = 480,
    parameter int V_FP   = 10,
    parameter int V_SYNC = 2,
    parameter int V_BP   = 33
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic                 newline,
    output logic                 advance,
    output logic [7:0]           line,
    input  logic [3*BPP-1:0]     pixel,
    output logic [BPP-1:0]       vga_red,
    output logic [BPP-1:0]       vga_grn,
    output logic [BPP-1:0]       vga_blu,
    output logic                 vga_hsync,
    output logic                 vga_vsync,
    output logic                 frame
);

    localparam int H_BLANK = H_FP + H_SYNC + H_BP;
    localparam int H_TOT   = H_BLANK + H_VIS;
    localparam int V_TOT   = V_VIS + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST     = 10'(H_TOT - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOT - 1);
    localparam logic [9:0] H_VIS_BEG  = 10'(H_BLANK);
    localparam logic [9:0] H_SYNC_BEG = 10'(H_FP);
    localparam logic [9:0] H_SYNC_END = 10'(H_FP + H_SYNC);
    localparam logic [9:0] V_VIS_END  = 10'(V_VIS);
    localparam logic [9:0] V_SYNC_BEG = 10'(V_VIS + V_FP);
    localparam logic [9:0] V_SYNC_END = 10'(V_VIS + V_FP + V_SYNC);

    logic [9:0] h, v;
    logic [9:0] h_nxt, v_nxt;
    logic       vis_nxt, newline_nxt, advance_nxt, frame_nxt;
    logic       hsync_nxt, vsync_nxt;
    logic       hsync_d, vsync_d;

    always_comb begin
        h_nxt = h + 10'd1;
        v_nxt = v;
        if (h == H_LAST) begin
            h_nxt = '0;
            v_nxt = (v == V_LAST) ? '0 : v + 10'd1;
        end
        vis_nxt     = (v_nxt < V_VIS_END);
        newline_nxt = (h_nxt == '0) && vis_nxt;
        advance_nxt = (h_nxt >= H_VIS_BEG) && vis_nxt;
        frame_nxt   = (h_nxt == '0) && (v_nxt == '0);
        hsync_nxt   = !((h_nxt >= H_SYNC_BEG) && (h_nxt < H_SYNC_END));
        vsync_nxt   = !((v_nxt >= V_SYNC_BEG) && (v_nxt < V_SYNC_END));
    end

    // Reset parks the raster on the last clock of a frame so release starts at (0,0).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h       <= H_LAST;
            v       <= V_LAST;
            newline <= 1'b0;
            advance <= 1'b0;
            frame   <= 1'b0;
            line    <= '0;
            hsync_d <= 1'b1;
            vsync_d <= 1'b1;
        end else begin
            h       <= h_nxt;
            v       <= v_nxt;
            newline <= newline_nxt;
            advance <= advance_nxt;
            frame   <= frame_nxt;
            hsync_d <= hsync_nxt;
            vsync_d <= vsync_nxt;
            if (newline_nxt)
                line <= v_nxt[8:1];
        end
    end

    // Extra sync stage matches the one-clock pixel register below.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vga_red   <= '0;
            vga_grn   <= '0;
            vga_blu   <= '0;
            vga_hsync <= 1'b1;
            vga_vsync <= 1'b1;
        end else begin
            vga_red   <= advance ? pixel[3*BPP-1 -: BPP] : '0;
            vga_grn   <= advance ? pixel[2*BPP-1 -: BPP] : '0;
            vga_blu   <= advance ? pixel[BPP-1   -: BPP] : '0;
            vga_hsync <= hsync_d;
            vga_vsync <= vsync_d;
        end
    end

endmodule

// File: doc/vga_scanout.md
# vga_scanout

Raster timing generator and final pixel output stage for the character display. Runs a 640x480@60 raster (25 MHz pixel clock) and drives the `newline` / `advance` / `line` strobes into the character pixel engine. Registers the returned `pixel` value, gated by blanking, onto the VGA RGB pins. Generates `hsync` and `vsync` aligned with the registered pixel data.

## Interface
Parameters:
- `BPP`, 2: bits per colour channel; `pixel` is 3*BPP wide.
- `H_VIS`, 640: visible pixels per line.
- `H_FP`, 16: horizontal front porch, in clocks.
- `H_SYNC`, 96: horizontal sync width, in clocks.
- `H_BP`, 48: horizontal back porch, in clocks.
- `V_VIS`, 480: visible raster lines; must be even, at most 512.
- `V_FP`, 10: vertical front porch, in lines.
- `V_SYNC`, 2: vertical sync width, in lines.
- `V_BP`, 33: vertical back porch, in lines.

Ports:
- `clk`  in  1: pixel clock. One clock; the only clock.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `newline`  out  1: one-clock strobe on the first clock of each visible raster line.
- `advance`  out  1: high on each visible pixel clock.
- `line`  out  8: visible line index 0..V_VIS/2-1. Each value is displayed on two raster lines.
- `pixel`  in  3*BPP: colour from the pixel engine, packed {R,G,B}. Valid in the same clock as `advance`.
- `vga_red`, `vga_grn`, `vga_blu`  out  BPP each: registered colour outputs.
- `vga_hsync`, `vga_vsync`  out  1 each: sync outputs, active low.
- `frame`  out  1: one-clock strobe at raster position (h=0, v=0).

## Operation
- Internal counters:
  - h: 10 bits, runs 0..H_TOT-1, where H_TOT = H_FP+H_SYNC+H_BP+H_VIS (800).
  - v: 10 bits, runs 0..V_TOT-1, where V_TOT = V_VIS+V_FP+V_SYNC+V_BP (525).
  - h increments every clock. When h wraps to 0, v increments. When v reaches V_TOT-1 and h wraps, v wraps to 0.
- Horizontal layout:
  - front porch: h in [0, H_FP)
  - sync: h in [H_FP, H_FP+H_SYNC)
  - back porch: up to H_BLANK = H_FP+H_SYNC+H_BP (160)
  - visible: h in [H_BLANK, H_TOT)
- Vertical layout:
  - visible: v in [0, V_VIS)
  - front porch: next V_FP lines
  - sync: next V_SYNC lines
  - back porch: remaining lines
- Strobes are registered. Each is computed from the next counter state, so in the clock where internal h=X and v=Y, the output reflects (X, Y).
- `newline` = (h==0 && v<V_VIS). This gives the pixel engine H_BLANK clocks to preload before the first `advance`.
- `advance` = (h>=H_BLANK && v<V_VIS). It is high for exactly H_VIS consecutive clocks per visible line.
- `line`:
  - Loads v[8:1] in the clock `newline` asserts.
  - Otherwise holds its value, including through vertical blanking, where it stays at V_VIS/2-1.
- `frame` = (h==0 && v==0).
- Pixel stage: on each edge, RGB <= advance ? pixel : 0. RGB is therefore forced to 0 throughout blanking.
- Syncs:
  - Decoded from the same position as `advance`, then passed through one extra register stage.
  - Result: `vga_hsync`/`vga_vsync` change on the same edge as the RGB output for that position.
  - `vga_vsync` is low for every clock of lines v in [V_VIS+V_FP, V_VIS+V_FP+V_SYNC).

## Timing
- Reset (rst_n low, asynchronous):
  - h=H_TOT-1, v=V_TOT-1.
  - `newline`, `advance`, `frame` = 0; `line` = 0.
  - RGB = 0; `vga_hsync` = `vga_vsync` = 1.
  - This state is consistent with the last clock of a frame.
- First rising edge after `rst_n` deasserts: enters (h=0, v=0). `frame`=1, `newline`=1, `line`=0 in that clock.
- Reset asserted mid-line or mid-frame:
  - All outputs take their reset values immediately.
  - The raster restarts from (0,0) after release. No partial line is emitted.
- Latency:
  - `pixel` sampled with `advance` appears on RGB one clock later.
  - A sync edge for position (h,v) also appears one clock after the clock in which the strobes reflect (h,v).
- Per visible line: exactly 1 `newline` and H_VIS `advance` clocks. First `advance` is H_BLANK clocks after `newline`.
- Per frame: exactly V_VIS `newline` strobes and one `frame` strobe. Frame period is H_TOT*V_TOT clocks (420000).
- `line` sequence per frame: 0,0,1,1,...,V_VIS/2-1 (twice), then holds.

## Test plan
- Reset values:
  - Stimulus: hold rst_n low for 5 clocks.
  - Required: all outputs at the reset values listed above.
  - Required: first edge after release gives `frame`=1, `newline`=1, `line`=0.
- Horizontal timing:
  - Stimulus: run 2 lines.
  - Required: `newline` period 800 clocks; `advance` high for clocks 160..799 of each line (640 clocks).
  - Required: `vga_hsync` low for 96 clocks, falling 17 clocks after `newline`.
- Vertical timing and line doubling:
  - Stimulus: run 2 full frames.
  - Required: 480 `newline` strobes and 1 `frame` strobe per frame; `frame` period 420000 clocks.
  - Required: `line` goes 0,0,1,1..239,239, then holds 239 during blanking.
  - Required: `vga_vsync` low for 1600 clocks.
- Pixel gating:
  - Stimulus: drive `pixel`=6'h3F constantly.
  - Required: RGB=3/3/3 exactly on clocks 161..800 relative to `newline` (1 clock after each `advance`); 0 elsewhere, including all of vblank.
- Alignment:
  - Stimulus: drive `pixel`=h[5:0] from a bench model.
  - Required: RGB value at each clock equals the value driven one clock earlier.
  - Required: first visible RGB value on each line is 6'h20 (h=160).
- Mid-frame reset:
  - Stimulus: assert rst_n at v=300, h=500 for 3 clocks.
  - Required: outputs go to reset values asynchronously.
  - Required: next `frame` strobe on the first edge after release; a full 420000-clock frame follows.
